alu_pipe_mc: RTL

//  Parametrised successor to the single-cycle EX-stage ALU. Same opcode map and flag

---
 rtl/alu_pipe_mc.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: two-stage valid/ready EX ALU with a saturating signed ADD/SUB,
// shifts, lane ops, V/N/Z flag register, and an iterative shift-add signed MUL.

// One PADDSB lane: signed add that clamps to the lane's min/max on overflow.
module alu_pipe_mc_lane #(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum
);
  logic [LANE_W:0] raw;
  assign raw = {a[LANE_W-1], a} + {b[LANE_W-1], b};

  // Top two bits of the sign-extended sum disagree exactly when the lane overflowed.
  always_comb begin
    if (raw[LANE_W] != raw[LANE_W-1]) sum = {raw[LANE_W], {(LANE_W-1){~raw[LANE_W]}}};
    else                              sum = raw[LANE_W-1:0];
  end
endmodule

module alu_pipe_mc #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             neg,
  output logic             zero,
  output logic             flags_we,
  output logic             illegal
);
  localparam int SH_W      = $clog2(WIDTH);
  localparam int NUM_LANES = WIDTH / LANE_W;
  localparam int CNT_W     = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
                         OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PAD = 4'h7,
                         OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
                         OP_MUL = 4'hC;

  localparam logic [0:0] ST_IDLE = 1'b0, ST_BUSY = 1'b1;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  // Result plus the flag writes it carries; flags commit only when consumed.
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ill;
    logic             wz;   // write Z
    logic             wnv;  // write N and V
    logic             v;
  } s2_t;

  logic             s1_valid, s2_valid;
  s1_t              s1;
  s2_t              s2, alu_s2, mul_s2;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mcd, acc_nx;
  logic [WIDTH-1:0] mpl;
  logic             mneg;

  logic adv, idle, s1_go, s1_is_mul, mul_start, alu_load, mul_done, consume;

  assign adv       = !s2_valid | out_ready;
  assign idle      = (state == ST_IDLE);
  assign s1_go     = s1_valid & adv & idle;
  assign s1_is_mul = (s1.op == OP_MUL);
  assign mul_start = s1_go & s1_is_mul;
  assign alu_load  = s1_go & !s1_is_mul;
  assign mul_done  = !idle & (cnt == CNT_W'(1));
  assign consume   = s2_valid & out_ready;
  // S1 can refill while a MUL is busy; it only frees up when its op moves to S2.
  assign in_ready  = !s1_valid | alu_load;

  assign out_valid = s2_valid;
  assign result    = s2.res;
  assign illegal   = s2.ill;

  // ---------------- lane datapath ----------------
  logic [NUM_LANES-1:0][LANE_W-1:0] a_lanes, b_lanes, pad_lanes;
  logic [WIDTH-1:0] red_sum;
  assign a_lanes = s1.a;
  assign b_lanes = s1.b;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    alu_pipe_mc_lane #(.LANE_W(LANE_W)) u_lane (
      .a   (a_lanes[g]),
      .b   (b_lanes[g]),
      .sum (pad_lanes[g])
    );
  end

  // Reduction: sign-extend every lane of A and B to WIDTH and add them all.
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      red_sum = red_sum
              + {{(WIDTH-LANE_W){a_lanes[i][LANE_W-1]}}, a_lanes[i]}
              + {{(WIDTH-LANE_W){b_lanes[i][LANE_W-1]}}, b_lanes[i]};
    end
  end

  // ---------------- single-cycle ops ----------------
  logic [WIDTH:0]   add_raw, sub_raw;
  logic             add_ovf, sub_ovf;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] sll_r, sra_r, ror_r;

  assign add_raw = {s1.a[WIDTH-1], s1.a} + {s1.b[WIDTH-1], s1.b};
  assign sub_raw = {s1.a[WIDTH-1], s1.a} - {s1.b[WIDTH-1], s1.b};
  assign add_ovf = add_raw[WIDTH] != add_raw[WIDTH-1];
  assign sub_ovf = sub_raw[WIDTH] != sub_raw[WIDTH-1];
  assign sh      = s1.b[SH_W-1:0];
  assign sll_r   = s1.a << sh;
  assign sra_r   = $unsigned($signed(s1.a) >>> sh);
  assign ror_r   = WIDTH'({s1.a, s1.a} >> sh);

  // Decode S1 into the S2 payload for every op that completes in one cycle.
  always_comb begin
    alu_s2 = '0;
    case (s1.op)
      OP_ADD: begin
        alu_s2.res = add_ovf ? {add_raw[WIDTH], {(WIDTH-1){~add_raw[WIDTH]}}} : add_raw[WIDTH-1:0];
        alu_s2.v   = add_ovf;
        alu_s2.wz  = 1'b1;
        alu_s2.wnv = 1'b1;
      end
      OP_SUB: begin
        alu_s2.res = sub_ovf ? {sub_raw[WIDTH], {(WIDTH-1){~sub_raw[WIDTH]}}} : sub_raw[WIDTH-1:0];
        alu_s2.v   = sub_ovf;
        alu_s2.wz  = 1'b1;
        alu_s2.wnv = 1'b1;
      end
      OP_XOR: begin alu_s2.res = s1.a ^ s1.b; alu_s2.wz = 1'b1; end
      OP_SLL: begin alu_s2.res = sll_r;       alu_s2.wz = 1'b1; end
      OP_SRA: begin alu_s2.res = sra_r;       alu_s2.wz = 1'b1; end
      OP_ROR: begin alu_s2.res = ror_r;       alu_s2.wz = 1'b1; end
      OP_RED: alu_s2.res = red_sum;
      OP_PAD: alu_s2.res = pad_lanes;
      OP_LW, OP_SW: alu_s2.res = s1.a + s1.b;
      OP_LLB: alu_s2.res = {s1.a[WIDTH-1:WIDTH/2], s1.b[WIDTH/2-1:0]};
      OP_LHB: alu_s2.res = {s1.b[WIDTH/2-1:0], s1.a[WIDTH/2-1:0]};
      default: alu_s2.ill = 1'b1;  // MUL never reaches here via alu_load
    endcase
  end

  // ---------------- iterative MUL ----------------
  logic mul_sat;
  assign acc_nx  = acc + (mpl[0] ? mcd : '0);
  // Magnitude limit is 2^(W-1)-1 for positive products and 2^(W-1) for negative.
  assign mul_sat = mneg ? (|acc_nx[2*WIDTH-1:WIDTH] | (acc_nx[WIDTH-1] & |acc_nx[WIDTH-2:0]))
                        : |acc_nx[2*WIDTH-1:WIDTH-1];

  // Final product formatting on the last shift-add step.
  always_comb begin
    mul_s2     = '0;
    mul_s2.wz  = 1'b1;
    mul_s2.wnv = 1'b1;
    mul_s2.v   = mul_sat;
    if (mul_sat)   mul_s2.res = {mneg, {(WIDTH-1){~mneg}}};
    else if (mneg) mul_s2.res = ~acc_nx[WIDTH-1:0] + WIDTH'(1);
    else           mul_s2.res = acc_nx[WIDTH-1:0];
  end

  // MUL sequencer: load magnitudes on start, one shift-add per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcd   <= '0;
      mpl   <= '0;
      mneg  <= 1'b0;
    end else if (mul_start) begin
      state <= ST_BUSY;
      cnt   <= CNT_W'(WIDTH);
      acc   <= '0;
      mcd   <= {{WIDTH{1'b0}}, (s1.a[WIDTH-1] ? -s1.a : s1.a)};
      mpl   <= s1.b[WIDTH-1] ? -s1.b : s1.b;
      mneg  <= s1.a[WIDTH-1] ^ s1.b[WIDTH-1];
    end else if (!idle) begin
      acc <= acc_nx;
      mcd <= mcd << 1;
      mpl <= mpl >> 1;
      cnt <= cnt - CNT_W'(1);
      if (mul_done) state <= ST_IDLE;
    end
  end

  // S1 operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_valid & in_ready) begin
      s1_valid <= 1'b1;
      s1       <= '{op: opcode, a: op_a, b: op_b};
    end else if (s1_go) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 result register. S2 is always empty when a MUL finishes, because nothing
  // else can enter S2 while the sequencer is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (alu_load) begin
      s2_valid <= 1'b1;
      s2       <= alu_s2;
    end else if (mul_done) begin
      s2_valid <= 1'b1;
      s2       <= mul_s2;
    end else if (consume) begin
      s2_valid <= 1'b0;
    end
  end

  // Flag register commits when the result is consumed; flags_we follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl     <= 1'b0;
      neg      <= 1'b0;
      zero     <= 1'b0;
      flags_we <= 1'b0;
    end else begin
      flags_we <= consume & (s2.wz | s2.wnv);
      if (consume & s2.wz) zero <= (s2.res == '0);
      if (consume & s2.wnv) begin
        neg  <= s2.res[WIDTH-1];
        ovfl <= s2.v;
      end
    end
  end
endmodule
